operand_fetch: RTL and testbench

- Operand-fetch stage directly upstream of the 16-bit ALU in the RISC datapath.
- Holds the 8x16 general register file and sequences reads of Rn into latch A and Rm into latch B.
- Applies the 1-bit shifter to B and the A/B source selects, then presents Ain/Bin to the ALU under a valid/ready handshake.
- Writeback from downstream (ALU result or memory) enters through a dedicated write port.

---
 rtl/operand_fetch_pkg.sv | 37 +++
 rtl/operand_fetch_if.sv | 32 +++
 rtl/operand_fetch_regfile.sv | 27 ++
 rtl/operand_fetch.sv | 79 +++++++
 tb/tb_operand_fetch.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage and the ALU it feeds:
// datapath sizes, FSM encoding, shift op codes and the B-operand shifter.
package operand_fetch_pkg;

    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int RW   = $clog2(NREG);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_A  = 2'd1;
    localparam logic [1:0] RD_B  = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef struct packed {
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [1:0]    shift;
        logic          asel;
        logic          bsel;
        logic [W-1:0]  sximm5;
    } req_t;

    function automatic logic [W-1:0] shift_b(input logic [1:0] op, input logic [W-1:0] b);
        case (op)
            SH_LSL:  return {b[W-2:0], 1'b0};
            SH_LSR:  return {1'b0, b[W-1:1]};
            SH_ASR:  return {b[W-1], b[W-1:1]};
            default: return b;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Request, operand-output and writeback signals of the operand-fetch stage.
// master = upstream/downstream environment, slave = operand_fetch itself.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic          start;
    logic          ready;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [1:0]    shift;
    logic          asel;
    logic          bsel;
    logic [W-1:0]  sximm5;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Ain;
    logic [W-1:0]  Bin;
    logic          wb_en;
    logic [RW-1:0] wb_num;
    logic [W-1:0]  wb_data;

    modport master (
        output start, rn, rm, shift, asel, bsel, sximm5, out_ready, wb_en, wb_num, wb_data,
        input  ready, out_valid, Ain, Bin
    );

    modport slave (
        input  start, rn, rm, shift, asel, bsel, sximm5, out_ready, wb_en, wb_num, wb_data,
        output ready, out_valid, Ain, Bin
    );

endinterface

// File: rtl/operand_fetch_regfile.sv
// 8x16 general register file: one write port, one combinational read port.
// A read in the same cycle as a write to that register returns the old value.
module operand_fetch_regfile
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_num,
    input  logic [W-1:0]  wb_data,
    input  logic [RW-1:0] rd_num,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_num] <= wb_data;
        end
    end

    assign rd_data = regs[rd_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads Rn then Rm into latches A/B, presents Ain/Bin to the ALU.
// Optional REGFILE_FWD_EN: a writeback landing on the register being read is forwarded.
//
//   state | meaning
//   IDLE  | ready for a request; latch request fields on start
//   RD_A  | A <= R[rn]
//   RD_B  | B <= R[rm]
//   VALID | Ain/Bin held until out_ready
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    operand_fetch_if.slave bus
);

    logic [1:0]    state;
    req_t          req_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [RW-1:0] rd_num;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  rd_val;

    // Single read port: Rn during RD_A, Rm otherwise.
    assign rd_num = (state == RD_A) ? req_q.rn : req_q.rm;

    operand_fetch_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (bus.wb_en),
        .wb_num  (bus.wb_num),
        .wb_data (bus.wb_data),
        .rd_num  (rd_num),
        .rd_data (rd_data)
    );

`ifdef REGFILE_FWD_EN
    assign rd_val = (bus.wb_en && (bus.wb_num == rd_num)) ? bus.wb_data : rd_data;
`else
    assign rd_val = rd_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        req_q <= '{rn: bus.rn, rm: bus.rm, shift: bus.shift,
                                   asel: bus.asel, bsel: bus.bsel, sximm5: bus.sximm5};
                        state <= RD_A;
                    end
                end
                RD_A: begin
                    a_q   <= rd_val;
                    state <= RD_B;
                end
                RD_B: begin
                    b_q   <= rd_val;
                    state <= VALID;
                end
                default: begin
                    if (bus.out_ready) state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.out_valid = (state == VALID);
    assign bus.Ain       = req_q.asel ? '0 : a_q;
    assign bus.Bin       = req_q.bsel ? req_q.sximm5 : shift_b(req_q.shift, b_q);

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register-file model plus an expected-operand queue.
module tb_operand_fetch;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if bus();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rf_m [8];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_b(input logic [1:0] sh, input logic [15:0] b);
        logic [15:0] r;
        r = b;
        if (sh == 2'b01) r = b << 1;
        else if (sh == 2'b10) r = b >> 1;
        else if (sh == 2'b11) r = $unsigned($signed(b) >>> 1);
        return r;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] n, input logic [15:0] d);
        bus.wb_en = 1'b1; bus.wb_num = n; bus.wb_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.wb_en = 1'b0;
        rf_m[n] = d;
    endtask

    // Drives a request through the accept edge and the RD_A cycle; returns in RD_B.
    task automatic issue(input logic [2:0] rn_i, input logic [2:0] rm_i, input logic [1:0] sh_i,
                         input logic asel_i, input logic bsel_i, input logic [15:0] imm_i,
                         input logic wb_i, input logic [2:0] wn_i, input logic [15:0] wd_i);
        logic [15:0] ea, eb;
        bus.start = 1'b1; bus.rn = rn_i; bus.rm = rm_i; bus.shift = sh_i;
        bus.asel = asel_i; bus.bsel = bsel_i; bus.sximm5 = imm_i;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.rn = ~rn_i; bus.rm = ~rm_i; bus.shift = ~sh_i;
        bus.asel = ~asel_i; bus.bsel = ~bsel_i; bus.sximm5 = ~imm_i;
        ea = rf_m[rn_i];
`ifdef REGFILE_FWD_EN
        if (wb_i && wn_i == rn_i) ea = wd_i;
`endif
        if (wb_i) begin
            bus.wb_en = 1'b1; bus.wb_num = wn_i; bus.wb_data = wd_i;
        end
        @(posedge clk);
        @(negedge clk);
        bus.wb_en = 1'b0;
        if (wb_i) rf_m[wn_i] = wd_i;
        eb = rf_m[rm_i];
        exp_q.push_back({asel_i ? 16'h0000 : ea, bsel_i ? imm_i : model_b(sh_i, eb)});
    endtask

    // Waits for out_valid, compares against the queue, holds off out_ready for hold cycles.
    task automatic collect(input string tag, input int hold);
        logic [31:0] exp;
        int cyc;
        check({tag, "_rdb_invalid"}, 32'(bus.out_valid), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd1);
        if (!bus.out_valid || exp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        check({tag, "_operands"}, {bus.Ain, bus.Bin}, exp);
        for (int i = 0; i < hold; i++) begin
            bus.start = i[0];
            bus.rn = 3'(i); bus.rm = 3'(i + 1); bus.asel = 1'b0; bus.bsel = 1'b0;
            @(negedge clk);
            check({tag, "_hold"}, {bus.Ain, bus.Bin}, exp);
            check({tag, "_hold_ready"}, {31'd0, bus.ready}, 32'd0);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, bus.ready, bus.out_valid}, 32'h2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.rn = '0; bus.rm = '0; bus.shift = '0; bus.asel = 1'b0;
        bus.bsel = 1'b0; bus.sximm5 = '0; bus.out_ready = 1'b0;
        bus.wb_en = 1'b0; bus.wb_num = '0; bus.wb_data = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_state", {bus.ready, bus.out_valid, 14'd0, bus.Ain | bus.Bin}, {1'b1, 1'b0, 30'd0});

        // Abort mid-RD_B: outputs clear asynchronously and the register file is wiped.
        wr(3'd1, 16'h7777);
        wr(3'd3, 16'h1234);
        issue(3'd1, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        check("pre_reset_ain", 32'(bus.Ain), 32'h7777);
        #1 reset = 1'b1;
        #1;
        check("reset_async", {bus.ready, bus.out_valid, 14'd0, bus.Ain | bus.Bin}, {1'b1, 1'b0, 30'd0});
        exp_q.delete();
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_idle", {30'd0, bus.ready, bus.out_valid}, 32'h2);
        issue(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        collect("r3_zero", 0);

        // Basic fetch
        wr(3'd1, 16'h0005);
        wr(3'd2, 16'h0003);
        issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        collect("basic", 0);

        // Shifts on B
        wr(3'd2, 16'h8001);
        for (int s = 1; s < 4; s++) begin
            issue(3'd1, 3'd2, 2'(s), 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
            collect($sformatf("shift%0d", s), 0);
        end

        // Selects with backpressure
        issue(3'd1, 3'd2, 2'b01, 1'b1, 1'b1, 16'hFFF0, 1'b0, 3'd0, 16'h0);
        collect("sel_bp", 5);

        // rn == rm with shift
        wr(3'd6, 16'hA5A5);
        issue(3'd6, 3'd6, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        collect("same_reg", 0);

        // Write collision on Rn during RD_A
        wr(3'd4, 16'h1111);
        issue(3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 3'd4, 16'h2222);
        collect("collide_a", 0);
        issue(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        collect("r4_after", 0);

        // Write to Rm during RD_A is visible in RD_B
        wr(3'd5, 16'h0055);
        issue(3'd1, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 3'd5, 16'h00AA);
        collect("rm_wr_rda", 0);

        // Randomised fetches
        for (int k = 0; k < 10; k++) begin
            wr(3'($urandom_range(0, 7)), 16'($urandom()));
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom()),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()));
            collect("rand", int'($urandom_range(0, 2)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
